// File: rtl/lz77_match_engine_if.sv
// lz77_match_engine_if: window-pair request and token response handshakes of the LZ77 match engine.
interface lz77_match_engine_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int SEARCH_SIZE    = 16,
    parameter int LOOKAHEAD_SIZE = 8,
    parameter int OW             = $clog2(SEARCH_SIZE + 1),
    parameter int LW             = $clog2(LOOKAHEAD_SIZE)
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [SEARCH_SIZE*DATA_WIDTH-1:0]    search_in;
    logic [OW-1:0]                        search_count;
    logic [LOOKAHEAD_SIZE*DATA_WIDTH-1:0] lookahead_in;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [OW-1:0]                        match_offset;
    logic [LW-1:0]                        match_length;
    logic [DATA_WIDTH-1:0]                next_char;

    modport master (
        output in_valid, search_in, search_count, lookahead_in, out_ready,
        input  in_ready, out_valid, match_offset, match_length, next_char
    );
    modport slave (
        input  in_valid, search_in, search_count, lookahead_in, out_ready,
        output in_ready, out_valid, match_offset, match_length, next_char
    );
endinterface

// File: rtl/lz77_match_engine.sv
// lz77_match_engine: multi-cycle LZ77 longest-match search, one candidate offset per clock,
// emitting one (offset, length, next_char) token per accepted window pair.
module lz77_match_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int SEARCH_SIZE    = 16,
    parameter int LOOKAHEAD_SIZE = 8,
    parameter int MIN_MATCH      = 1,
    parameter int OW             = $clog2(SEARCH_SIZE + 1),
    parameter int LW             = $clog2(LOOKAHEAD_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    lz77_match_engine_if.slave  io,
    output logic                busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam int SW = SEARCH_SIZE * DATA_WIDTH;
    localparam int AW = LOOKAHEAD_SIZE * DATA_WIDTH;
    localparam logic [LW-1:0] MAX_LEN = LW'(LOOKAHEAD_SIZE - 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(SEARCH_SIZE);

    logic [1:0]            state_q, state_d;
    logic [SW-1:0]         srch_q, srch_d;
    logic [AW-1:0]         look_q, look_d;
    logic [OW-1:0]         cnt_q, cnt_d, cand_q, cand_d;
    logic [OW-1:0]         best_off_q, best_off_d, off_q, off_d;
    logic [LW-1:0]         best_len_q, best_len_d, len_q, len_d;
    logic [DATA_WIDTH-1:0] nc_q, nc_d;
    logic [LW-1:0]         cand_len;

    // Positions at or beyond the candidate distance read the lookahead itself (overlapping run).
    always_comb begin
        logic                  run;
        logic [DATA_WIDTH-1:0] src;
        run      = 1'b1;
        src      = '0;
        cand_len = '0;
        for (int j = 0; j < LOOKAHEAD_SIZE - 1; j++) begin
            src      = (j < int'(cand_q)) ? srch_q[(int'(cand_q) - 1 - j)*DATA_WIDTH +: DATA_WIDTH]
                                          : look_q[(j - int'(cand_q))*DATA_WIDTH +: DATA_WIDTH];
            run      = run && (src == look_q[j*DATA_WIDTH +: DATA_WIDTH]);
            cand_len = cand_len + LW'(run);
        end
    end

    always_comb begin
        logic [OW-1:0] clamped;
        logic [OW-1:0] nb_off;
        logic [LW-1:0] nb_len;
        logic          lit;
        state_d    = state_q;
        srch_d     = srch_q;
        look_d     = look_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        best_off_d = best_off_q;
        best_len_d = best_len_q;
        off_d      = off_q;
        len_d      = len_q;
        nc_d       = nc_q;
        clamped    = (io.search_count > MAX_CNT) ? MAX_CNT : io.search_count;
        nb_len     = (cand_len > best_len_q) ? cand_len : best_len_q;
        nb_off     = (cand_len > best_len_q) ? cand_q : best_off_q;
        lit        = int'(nb_len) < MIN_MATCH;
        if (state_q == IDLE && io.in_valid) begin
            srch_d     = io.search_in;
            look_d     = io.lookahead_in;
            cnt_d      = clamped;
            cand_d     = OW'(1);
            best_off_d = '0;
            best_len_d = '0;
            state_d    = (clamped == '0) ? DONE : SEARCH;
            if (clamped == '0) begin
                off_d = '0;
                len_d = '0;
                nc_d  = io.lookahead_in[0 +: DATA_WIDTH];
            end
        end else if (state_q == SEARCH) begin
            best_off_d = nb_off;
            best_len_d = nb_len;
            cand_d     = cand_q + OW'(1);
            if (cand_q == cnt_q || nb_len == MAX_LEN) begin
                state_d = DONE;
                off_d   = lit ? '0 : nb_off;
                len_d   = lit ? '0 : nb_len;
                nc_d    = look_q[int'(lit ? '0 : nb_len)*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (state_q == DONE && io.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            srch_q     <= '0;
            look_q     <= '0;
            cnt_q      <= '0;
            cand_q     <= '0;
            best_off_q <= '0;
            best_len_q <= '0;
            off_q      <= '0;
            len_q      <= '0;
            nc_q       <= '0;
        end else begin
            state_q    <= state_d;
            srch_q     <= srch_d;
            look_q     <= look_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            best_off_q <= best_off_d;
            best_len_q <= best_len_d;
            off_q      <= off_d;
            len_q      <= len_d;
            nc_q       <= nc_d;
        end
    end

    assign io.in_ready     = state_q == IDLE;
    assign io.out_valid    = state_q == DONE;
    assign io.match_offset = off_q;
    assign io.match_length = len_q;
    assign io.next_char    = nc_q;
    assign busy            = state_q != IDLE;
endmodule

// File: tb/tb_lz77_match_engine.sv
// tb_lz77_match_engine: directed vectors driven into a MIN_MATCH=1 and a MIN_MATCH=3 engine in lockstep.
module tb_lz77_match_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [127:0] search_in = '0;
    logic [4:0]  search_count = '0;
    logic [63:0] lookahead_in = '0;
    logic        busy_a, busy_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    lz77_match_engine_if ia ();
    lz77_match_engine_if ib ();

    assign ia.in_valid = in_valid;
    assign ia.out_ready = out_ready;
    assign ia.search_in = search_in;
    assign ia.search_count = search_count;
    assign ia.lookahead_in = lookahead_in;
    assign ib.in_valid = in_valid;
    assign ib.out_ready = out_ready;
    assign ib.search_in = search_in;
    assign ib.search_count = search_count;
    assign ib.lookahead_in = lookahead_in;

    lz77_match_engine #(.MIN_MATCH(1)) dut_a (.clk(clk), .rst_n(rst_n), .io(ia), .busy(busy_a));
    lz77_match_engine #(.MIN_MATCH(3)) dut_b (.clk(clk), .rst_n(rst_n), .io(ib), .busy(busy_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_search(input string s);
        search_in = '0;
        for (int i = 0; i < s.len(); i++) search_in[i*8 +: 8] = s[i];
    endtask

    task automatic set_look(input string s);
        lookahead_in = '0;
        for (int i = 0; i < s.len(); i++) lookahead_in[i*8 +: 8] = s[i];
    endtask

    task automatic run(input string tag, input int cnt, input int en,
                       input int eoa, input int ela, input logic [7:0] eca,
                       input int eob, input int elb, input logic [7:0] ecb);
        int n;
        @(negedge clk);
        search_count = cnt[4:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ia.out_valid && n < 40) begin
            n++;
            if (n == 1) check({tag, "_busy"}, {busy_a, ia.in_ready}, 2'b10);
            @(negedge clk);
        end
        check({tag, "_lat"}, n, en);
        check({tag, "_a"}, {ia.match_offset, ia.match_length, ia.next_char}, {eoa[4:0], ela[2:0], eca});
        check({tag, "_b"}, {ib.out_valid, ib.match_offset, ib.match_length, ib.next_char},
              {1'b1, eob[4:0], elb[2:0], ecb});
        if (out_ready) begin
            @(posedge clk);
            #1 check({tag, "_ret"}, {ia.out_valid, ia.in_ready, ib.in_ready}, 3'b011);
        end
    endtask

    initial begin
        #12;
        check("rst_state", {ia.out_valid, ia.in_ready, busy_a, ia.match_offset, ia.match_length, ia.next_char},
              {3'b010, 5'd0, 3'd0, 8'd0});
        @(negedge clk) rst_n = 1'b1;

        set_look("ABCDEFGH");
        set_search("");
        run("empty", 0, 0, 0, 0, "A", 0, 0, "A");

        set_look("ABCXYZWV");
        set_search("CBA");
        run("basic", 3, 3, 3, 3, "X", 3, 3, "X");

        set_look("aaaaaaaa");
        set_search("a");
        run("overlap", 1, 1, 1, 7, "a", 1, 7, "a");

        set_look("QRSTUVWX");
        set_search("abQdefghiQklmnop");
        run("tie", 16, 16, 3, 1, "R", 0, 0, "Q");
        run("clamp", 31, 16, 3, 1, "R", 0, 0, "Q");

        set_look("ABCDABCx");
        set_search("DCBA");
        run("early", 16, 4, 4, 7, "x", 4, 7, "x");

        set_look("MNOPQRST");
        set_search("abcNMfgh");
        out_ready = 1'b0;
        run("minm", 8, 8, 5, 2, "O", 0, 0, "M");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold", {ib.out_valid, ib.in_ready, ib.match_offset, ib.match_length, ib.next_char, ia.in_ready},
                  {2'b10, 5'd0, 3'd0, 8'h4D, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 check("hold_ret", {ia.out_valid, ia.in_ready}, 2'b01);

        @(negedge clk);
        search_count = 5'd8;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort", {ia.out_valid, ia.in_ready, busy_a, ia.match_offset, ia.match_length, ia.next_char, ib.in_ready},
                 {3'b010, 5'd0, 3'd0, 8'd0, 1'b1});
        @(negedge clk) rst_n = 1'b1;

        set_look("ABCXYZWV");
        set_search("CBA");
        run("post_rst", 3, 3, 3, 3, "X", 3, 3, "X");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
